// File: rtl/mole_hit_encoder.sv
// ============================================================================
//  Module   : mole_hit_encoder
//  Purpose  : Converts the board slide switches into a stream of mole
//             indices. Switch levels are synchronised and debounced as one
//             vector, every 0->1 press is queued in a pending bitmap, and
//             queued presses are emitted one index at a time, lowest index
//             first, over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   system clock, rising edge
//    rst_n      in   asynchronous active-low reset, synchronous release
//    sw_in      in   [N_IN-1:0]  raw asynchronous switch levels
//    hit_idx    out  [IDX_W-1:0] index of the pressed switch (when valid)
//    hit_valid  out  an index is presented
//    hit_ready  in   consumer accepts when hit_valid & hit_ready on an edge
//    pending    out  [N_IN-1:0]  presses queued but not yet emitted
//    overrun    out  sticky duplicate-press flag (MOLE_HIT_OVERRUN_EN only)
//  Configuration
//    MOLE_HIT_OVERRUN_EN : when defined, adds the overrun port and its logic.
// ============================================================================
`default_nettype none

module mole_hit_encoder #(
    parameter int N_IN            = 18,
    parameter int IDX_W           = 5,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  sw_in,
    output logic [IDX_W-1:0] hit_idx,
    output logic             hit_valid,
    input  logic             hit_ready,
    output logic [N_IN-1:0]  pending
`ifdef MOLE_HIT_OVERRUN_EN
    ,
    output logic             overrun
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [N_IN-1:0]  sync1_q;
    logic [N_IN-1:0]  sync2_q;
    logic [N_IN-1:0]  last_cand_q, last_cand_d;
    logic [N_IN-1:0]  db_state_q,  db_state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [N_IN-1:0]  pending_q,   pending_d;
    logic [IDX_W-1:0] hit_idx_q,   hit_idx_d;
    logic             hit_valid_q, hit_valid_d;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [N_IN-1:0]  cand_w;
    logic             db_upd_w;
    logic [N_IN-1:0]  rise_w;
    logic             load_w;
    logic [IDX_W-1:0] low_idx_w;
    logic [N_IN-1:0]  low_onehot_w;
    logic [N_IN-1:0]  clr_w;

    assign cand_w = sync2_q;

    // Debounce: a single counter covers the whole vector, so any bit that
    // moves restarts the settling window for every bit.
    always_comb begin
        last_cand_d = last_cand_q;
        db_state_d  = db_state_q;
        cnt_d       = cnt_q;
        db_upd_w    = 1'b0;
        if (cand_w != last_cand_q) begin
            cnt_d       = '0;
            last_cand_d = cand_w;
        end else if (cnt_q == CNT_MAX) begin
            // Counter holds here; db_state is refreshed every cycle while
            // stable, but only the first refresh can produce a rise.
            db_upd_w   = 1'b1;
            db_state_d = cand_w;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Presses only; releases never reach the queue.
    assign rise_w = db_upd_w ? (cand_w & ~db_state_q) : '0;

    // Lowest-set-bit priority encoder over the pending bitmap. Scanning
    // downwards lets the lowest hit overwrite the others.
    always_comb begin
        low_idx_w    = '0;
        low_onehot_w = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx_w       = IDX_W'(i);
                low_onehot_w    = '0;
                low_onehot_w[i] = 1'b1;
            end
        end
    end

    assign load_w = (|pending_q) && (!hit_valid_q || hit_ready);
    assign clr_w  = load_w ? low_onehot_w : '0;

    always_comb begin
        // A bit that rises on the same edge it is cleared ends set: that is
        // a fresh press, not the one being loaded.
        pending_d   = (pending_q & ~clr_w) | rise_w;
        hit_idx_d   = hit_idx_q;
        hit_valid_d = hit_valid_q;
        if (load_w) begin
            hit_idx_d   = low_idx_w;
            hit_valid_d = 1'b1;
        end else if (hit_valid_q && hit_ready) begin
            hit_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            last_cand_q <= '0;
            db_state_q  <= '0;
            cnt_q       <= '0;
            pending_q   <= '0;
            hit_idx_q   <= '0;
            hit_valid_q <= 1'b0;
        end else begin
            sync1_q     <= sw_in;
            sync2_q     <= sync1_q;
            last_cand_q <= last_cand_d;
            db_state_q  <= db_state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            hit_idx_q   <= hit_idx_d;
            hit_valid_q <= hit_valid_d;
        end
    end

    assign hit_idx   = hit_idx_q;
    assign hit_valid = hit_valid_q;
    assign pending   = pending_q;

`ifdef MOLE_HIT_OVERRUN_EN
    // Sticky: a bit pressed again while its earlier press is still queued
    // (and not leaving the queue this same edge).
    logic overrun_q;
    logic overrun_d;

    assign overrun_d = overrun_q | (|(rise_w & pending_q & ~clr_w));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mole_hit_encoder.sv
// ============================================================================
//  Module   : tb_mole_hit_encoder
//  Purpose  : Directed self-checking bench for mole_hit_encoder with a
//             short debounce window (DEBOUNCE_CYCLES=4, CNT_W=3).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mole_hit_encoder;

    localparam int N_IN  = 18;
    localparam int IDX_W = 5;

    logic             clk;
    logic             rst_n;
    logic [N_IN-1:0]  sw_in;
    logic [IDX_W-1:0] hit_idx;
    logic             hit_valid;
    logic             hit_ready;
    logic [N_IN-1:0]  pending;
`ifdef MOLE_HIT_OVERRUN_EN
    logic             overrun;
`endif

    mole_hit_encoder #(
        .N_IN            (N_IN),
        .IDX_W           (IDX_W),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_in     (sw_in),
        .hit_idx   (hit_idx),
        .hit_valid (hit_valid),
        .hit_ready (hit_ready),
        .pending   (pending)
`ifdef MOLE_HIT_OVERRUN_EN
        ,
        .overrun   (overrun)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Results of the most recent collect() call.
    int              beats[$];
    int              first_valid;
    logic [N_IN-1:0] pend_or;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs n clock cycles; after each edge records the cycle of the first
    // hit_valid, every index offered while hit_ready is high (a beat taken
    // at the next edge), and the union of pending seen.
    task automatic collect(input int n);
        beats.delete();
        first_valid = -1;
        pend_or     = '0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            pend_or = pend_or | pending;
            if (hit_valid && first_valid < 0) first_valid = k;
            if (hit_valid && hit_ready) beats.push_back(int'(hit_idx));
        end
    endtask

    task automatic check_beats(input string tag, input int n, input int b0, input int b1);
        check({tag, "_nbeats"}, 32'(beats.size()), 32'(n));
        if (n >= 1 && beats.size() >= 1) check({tag, "_beat0"}, 32'(beats[0]), 32'(b0));
        if (n >= 2 && beats.size() >= 2) check({tag, "_beat1"}, 32'(beats[1]), 32'(b1));
    endtask

    initial begin
        rst_n     = 1'b0;
        sw_in     = '0;
        hit_ready = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",   32'(hit_valid), 32'd0);
        check("rst_idx",     32'(hit_idx),   32'd0);
        check("rst_pending", 32'(pending),   32'd0);
`ifdef MOLE_HIT_OVERRUN_EN
        check("rst_overrun", 32'(overrun),   32'd0);
`endif
        rst_n = 1'b1;
        collect(50);
        check("idle_first_valid", 32'(first_valid), 32'hFFFF_FFFF);
        check("idle_pending",     32'(pend_or),     32'd0);

        // ---- single press on bit 5: 2 sync + 4 debounce + 1 + 1 = 8 ----
        hit_ready = 1'b1;
        sw_in     = 18'h00020;
        collect(30);
        check("single_latency", 32'(first_valid), 32'd8);
        check_beats("single", 1, 5, 0);
        check("single_pending", 32'(pending), 32'd0);

        // ---- release produces nothing ----
        sw_in = '0;
        collect(20);
        check_beats("release5", 0, 0, 0);

        // ---- glitch on bit 3 shorter than the window ----
        sw_in = 18'h00008;
        @(posedge clk); @(posedge clk); #1;
        sw_in = '0;
        collect(30);
        check("glitch_valid",   32'(first_valid), 32'hFFFF_FFFF);
        check("glitch_pending", 32'(pend_or),     32'd0);

        // ---- simultaneous presses with backpressure ----
        hit_ready = 1'b0;
        sw_in     = 18'h20001;
        collect(20);
        check("bp_valid",   32'(hit_valid), 32'd1);
        check("bp_idx",     32'(hit_idx),   32'd0);
        check("bp_pending", 32'(pending),   32'h20000);
        collect(10);
        check("bp_hold_valid",   32'(hit_valid), 32'd1);
        check("bp_hold_idx",     32'(hit_idx),   32'd0);
        check("bp_hold_pending", 32'(pending),   32'h20000);
        hit_ready = 1'b1;
        // First sample already follows the edge that takes idx 0, so the
        // offer seen at this instant is recorded by hand.
        if (hit_valid) beats.push_back(int'(hit_idx));
        begin
            int pre[$];
            pre = beats;
            collect(10);
            beats = {pre, beats};
        end
        check_beats("bp", 2, 0, 17);
        check("bp_after_valid", 32'(hit_valid), 32'd0);

        // ---- release and re-press bit 7 ----
        sw_in = '0;
        collect(20);
        check_beats("rel_all", 0, 0, 0);
        sw_in = 18'h00080;
        collect(20);
        check_beats("press7a", 1, 7, 0);
        sw_in = '0;
        collect(20);
        check_beats("release7", 0, 0, 0);
        sw_in = 18'h00080;
        collect(20);
        check_beats("press7b", 1, 7, 0);
        sw_in = '0;
        collect(20);

        // ---- duplicate press while still queued ----
        hit_ready = 1'b0;
        sw_in     = 18'h00004;
        collect(15);
        check("dup_idx",      32'(hit_idx),   32'd2);
        check("dup_valid",    32'(hit_valid), 32'd1);
        check("dup_pending0", 32'(pending),   32'd0);
        sw_in = 18'h00204;
        collect(15);
        check("dup_pending1", 32'(pending),   32'h00200);
        sw_in = 18'h00004;
        collect(15);
        check("dup_pending2", 32'(pending),   32'h00200);
`ifdef MOLE_HIT_OVERRUN_EN
        check("dup_overrun0", 32'(overrun),   32'd0);
`endif
        sw_in = 18'h00204;
        collect(15);
        check("dup_pending3", 32'(pending),   32'h00200);
`ifdef MOLE_HIT_OVERRUN_EN
        check("dup_overrun1", 32'(overrun),   32'd1);
`endif
        hit_ready = 1'b1;
        begin
            int pre[$];
            pre.delete();
            if (hit_valid) pre.push_back(int'(hit_idx));
            collect(10);
            beats = {pre, beats};
        end
        check_beats("dup", 2, 2, 9);

        // ---- asynchronous reset mid-stream ----
        hit_ready = 1'b0;
        sw_in     = 18'h00018;
        collect(15);
        check("mid_valid",   32'(hit_valid), 32'd1);
        check("mid_idx",     32'(hit_idx),   32'd3);
        check("mid_pending", 32'(pending),   32'h00010);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid",   32'(hit_valid), 32'd0);
        check("arst_idx",     32'(hit_idx),   32'd0);
        check("arst_pending", 32'(pending),   32'd0);
`ifdef MOLE_HIT_OVERRUN_EN
        check("arst_overrun", 32'(overrun),   32'd0);
`endif
        sw_in = '0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        hit_ready = 1'b1;
        collect(50);
        check("post_rst_valid",   32'(first_valid), 32'hFFFF_FFFF);
        check("post_rst_pending", 32'(pend_or),     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mole_hit_encoder.md
Name: mole_hit_encoder

Overview:
Input-side counterpart of the one-hot mole LED decoder: converts the 18 board slide switches into a stream of 5-bit mole indices, 0 to 17. Switch levels are synchronised and debounced. Each press (0->1 transition) is queued, and indices are emitted one at a time over a valid/ready handshake to the game FSM. The game FSM compares each index with the lit mole index to score a hit.

Parameters:
- N_IN, 18: number of switch inputs. Must be <= 2**IDX_W.
- IDX_W, 5: width of the emitted index.
- DEBOUNCE_CYCLES, 250000: cycles the synchronised vector must stay unchanged before it is accepted. This is 5 ms at 50 MHz. Must be >= 1.
- CNT_W, 18: debounce counter width. Must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- sw_in, input, N_IN: raw asynchronous switch levels.
- hit_idx, output, IDX_W: index of the pressed switch. Valid only while hit_valid=1.
- hit_valid, output, 1: an index is presented.
- hit_ready, input, 1: consumer accepts the index when hit_valid=1 and hit_ready=1 on the same edge.
- pending, output, N_IN: presses queued but not yet emitted. Debug visibility.

Behaviour:
- Reset (asynchronous assert, synchronous release): all of the following are 0.
  - synchroniser flops, last_cand, db_state, debounce counter, pending.
  - hit_idx, hit_valid, overrun.
- Synchroniser: 2 flops per bit. cand = second-stage output.
- Debounce (one counter for the whole vector):
  - If cand != last_cand: counter <= 0 and last_cand <= cand.
  - Else if counter == DEBOUNCE_CYCLES-1: db_state <= cand. Counter holds.
  - Else: counter++.
  - Any bit changing restarts the window for all bits.
- Rise detect: rise = cand & ~db_state, computed only on the cycle db_state updates. Otherwise rise = 0. Falling edges (releases) are ignored.
- Queue update: pending <= (pending & ~clr) | rise.
  - clr is the one-hot bit being loaded into the output this cycle.
  - If the same bit both rises and is cleared on one edge, it ends set. This is a new press.
- Output stage:
  - load is true when pending != 0 and (hit_valid == 0, or hit_valid and hit_ready are both 1).
  - On load: hit_idx <= index of the lowest set bit of pending, hit_valid <= 1, clr = that bit.
  - On accept with pending == 0: hit_valid <= 0.
  - While hit_valid=1 and hit_ready=0, hit_idx and hit_valid hold stable.
- Throughput: one index per cycle while hit_ready=1.
- Ordering: simultaneous presses are emitted in ascending index order.
- Latency: sw_in change to hit_valid is 2 (synchroniser) + DEBOUNCE_CYCLES + 1 (pending) + 1 (output) cycles, ±1.
- Switches already high at reset release are reported as presses once debounced. This is intentional: the game counts held switches.
- Bits N_IN..2**IDX_W-1 of any index are never produced.
- Reset mid-operation discards queued presses and any presented index. No partial handshake survives.

Optional Feature:
Macro: MOLE_HIT_OVERRUN_EN.
- Defined:
  - Adds port overrun (output, 1), a sticky flag.
  - Set when rise & pending & ~clr != 0, i.e. a bit is pressed again while its earlier press is still queued.
  - Cleared only by reset.
  - The duplicate press is merged into the single pending bit either way.
- Undefined: the port is absent, no extra logic is generated, and duplicates merge silently.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
1. Reset hygiene: assert rst_n=0 mid-stream with hit_valid=1 -> hit_valid=0, hit_idx=0, pending=0 immediately (asynchronous). After release with sw_in=0, no output for 50 cycles.
2. Single press: sw_in goes 0 -> 0x00020 and is held, hit_ready=1 -> exactly one beat with hit_idx=5, hit_valid high within 9 cycles. pending returns to 0 and there is no further beat.
3. Glitch reject: 2-cycle pulse on bit 3 (sw_in=0x00008 then back to 0) -> hit_valid stays 0 and pending stays 0.
4. Simultaneous presses with backpressure: sw_in 0 -> 0x20001, hit_ready=0 for 10 cycles -> hit_idx=0 held stable with hit_valid=1 and pending=0x20000. hit_ready=1 -> beat idx 0, then next cycle idx 17, then hit_valid=0.
5. Release and re-press: bit 7 press -> idx 7. Release (sw_in=0) -> no beat. Re-press -> second beat with idx 7.
6. Overrun (macro defined): press bit 2 with hit_ready=0 so idx 2 is presented and pending=0. Press bit 9 -> pending=0x00200. Release bit 9, then press it again -> overrun=1. After hit_ready=1, beats are 2 then 9 only. With the macro undefined, the same beats appear and there is no overrun port.
